// File: rtl/rle1_dec_arb_if.sv
// Handshake bundle joining the requester channel FIFOs, the frame arbiter and the shared rle1_dec.
// The arbiter takes the slave view; the requester/decoder environment takes the master view.
interface rle1_dec_arb_if #(
    parameter int unsigned NREQ = 2
);
    logic [2*NREQ-1:0] req_input_r;
    logic [NREQ-1:0]   req_input_r_vld;
    logic [NREQ-1:0]   req_input_r_rdy;
    logic [5:0]        req_output_s;
    logic [NREQ-1:0]   req_output_s_vld;
    logic [NREQ-1:0]   req_output_s_rdy;
    logic [1:0]        dec_input_r;
    logic              dec_input_r_vld;
    logic              dec_input_r_rdy;
    logic [5:0]        dec_output_s;
    logic              dec_output_s_vld;
    logic              dec_output_s_rdy;
    logic [NREQ-1:0]   grant;
    logic              busy;

    modport slave (
        input  req_input_r, req_input_r_vld, req_output_s_rdy,
        input  dec_input_r_rdy, dec_output_s, dec_output_s_vld,
        output req_input_r_rdy, req_output_s, req_output_s_vld,
        output dec_input_r, dec_input_r_vld, dec_output_s_rdy,
        output grant, busy
    );

    modport master (
        output req_input_r, req_input_r_vld, req_output_s_rdy,
        output dec_input_r_rdy, dec_output_s, dec_output_s_vld,
        input  req_input_r_rdy, req_output_s, req_output_s_vld,
        input  dec_input_r, dec_input_r_vld, dec_output_s_rdy,
        input  grant, busy
    );
endinterface

// File: rtl/rle1_dec_arb.sv
// Round-robin, frame-locked arbiter sharing one rle1_dec between NREQ requester streams.
// Grant covers FRAME_LEN input words, then holds through a drain until the decoder is quiet.
module rle1_dec_arb #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned FRAME_LEN    = 8,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    rle1_dec_arb_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_owner, w_owner_nxt;
    logic [IW-1:0] r_rr, w_rr_nxt;
    logic [7:0]    r_wcnt, w_wcnt_nxt;
    logic [3:0]    r_dcnt, w_dcnt_nxt;
    logic [IW-1:0] w_sel, w_idx;
    logic          w_found;
    logic [1:0]    w_own_word;
    logic          w_own_vld, w_own_ordy;
    logic          w_in_xfer, w_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_rr    <= '0;
            r_wcnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // First valid requester at or above the rr pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr;
        w_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IW'((32'(r_rr) + k) % NREQ);
            if (!w_found && bus.req_input_r_vld[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_own_word = '0;
        w_own_vld  = 1'b0;
        w_own_ordy = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_own_word = bus.req_input_r[2*i +: 2];
                w_own_vld  = bus.req_input_r_vld[i];
                w_own_ordy = bus.req_output_s_rdy[i];
            end
        end
    end

    assign w_in_xfer = (r_state == S_FEED) && w_own_vld && bus.dec_input_r_rdy;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_wcnt_nxt  = r_wcnt;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_FEED;
                    w_owner_nxt = w_sel;
                    w_wcnt_nxt  = '0;
                end
            end
            S_FEED: begin
                if (w_in_xfer) begin
                    if (r_wcnt == 8'(FRAME_LEN - 1)) begin
                        w_state_nxt = S_DRAIN;
                        w_wcnt_nxt  = '0;
                        w_dcnt_nxt  = '0;
                    end else begin
                        w_wcnt_nxt = r_wcnt + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                // A held (backpressured) output keeps vld high, so stalls restart the quiet count.
                if (bus.dec_output_s_vld) begin
                    w_dcnt_nxt = '0;
                end else if (r_dcnt == 4'(DRAIN_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_dcnt_nxt  = '0;
                    w_rr_nxt    = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                end else begin
                    w_dcnt_nxt = r_dcnt + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Data paths are pure muxes; every handshake output is forced low while reset is held.
    always_comb begin
        w_active             = !reset && (r_state != S_IDLE);
        bus.req_input_r_rdy  = '0;
        bus.req_output_s     = bus.dec_output_s;
        bus.req_output_s_vld = '0;
        bus.dec_input_r      = '0;
        bus.dec_input_r_vld  = 1'b0;
        bus.dec_output_s_rdy = 1'b0;
        bus.grant            = '0;
        if (w_active) begin
            bus.grant[r_owner]            = 1'b1;
            bus.req_output_s_vld[r_owner] = bus.dec_output_s_vld;
            bus.dec_output_s_rdy          = w_own_ordy;
            if (r_state == S_FEED) begin
                bus.dec_input_r              = w_own_word;
                bus.dec_input_r_vld          = w_own_vld;
                bus.req_input_r_rdy[r_owner] = bus.dec_input_r_rdy;
            end
        end
    end

    assign bus.busy = (r_state != S_IDLE);
endmodule
